reel_stop_ctrl: RTL and testbench

// - Front-end stage that drives the slot-reel display block. It sits directly upstream and

---
 rtl/reel_stop_ctrl.sv | 149 ++++++++++++++
 tb/tb_reel_stop_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reel_stop_ctrl.sv
// Stop-key debouncer and round FSM that drives the reel freeze inputs (SW1..SW3) of the reel stage.
// Optional macro ANY_ORDER_EN: when defined, reels may be frozen in any order instead of left-to-right.
module reel_stop_ctrl #(
  parameter int DEB_CYCLES      = 500000,
  parameter int MIN_SPIN_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n,
  input  logic       start_n,
  output logic [2:0] stop,
  output logic [1:0] stopped_cnt,
  output logic       all_stopped,
  output logic       round_start,
  output logic       press_ign
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (MIN_SPIN_CYCLES > 1) ? $clog2(MIN_SPIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {SPIN, STOPPING, DONE} state_t;

  logic [3:0] raw;
  logic [3:0] press;

  assign raw = {start_n, key_n};

  // Index 3 is the start key; indices 0..2 are the reel stop keys.
  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic          deb_prev_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_reg    <= 1'b1;
        sync2_reg    <= 1'b1;
        deb_reg      <= 1'b1;
        deb_prev_reg <= 1'b1;
        press_reg    <= 1'b0;
        cnt_reg      <= '0;
      end else begin
        sync1_reg    <= raw[gi];
        sync2_reg    <= sync1_reg;
        deb_prev_reg <= deb_reg;
        press_reg    <= deb_prev_reg & ~deb_reg;
        if (sync2_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign press[gi] = press_reg;
  end

  state_t        state_reg, state_next;
  logic [2:0]    stop_reg, stop_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          round_start_reg, round_start_next;
  logic          press_ign_reg, press_ign_next;

  logic [2:0] stop_press;
  logic       start_press;
  logic       multi;
  logic [1:0] sel;
  logic       timer_sat;
  logic       order_ok;
  logic       accept;

  assign stop_press  = press[2:0];
  assign start_press = press[3];
  assign multi       = (stop_press & (stop_press - 3'd1)) != 3'd0;
  assign sel         = stop_press[0] ? 2'd0 : (stop_press[1] ? 2'd1 : 2'd2);
  assign timer_sat   = (timer_reg == TW'(MIN_SPIN_CYCLES));
`ifdef ANY_ORDER_EN
  assign order_ok    = 1'b1;
`else
  assign order_ok    = (sel == cnt_reg);
`endif
  assign accept      = timer_sat && !stop_reg[sel] && order_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= SPIN;
      stop_reg        <= 3'b000;
      cnt_reg         <= 2'd0;
      timer_reg       <= '0;
      round_start_reg <= 1'b0;
      press_ign_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stop_reg        <= stop_next;
      cnt_reg         <= cnt_next;
      timer_reg       <= timer_next;
      round_start_reg <= round_start_next;
      press_ign_reg   <= press_ign_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    stop_next        = stop_reg;
    cnt_next         = cnt_reg;
    timer_next       = timer_sat ? timer_reg : timer_reg + 1'b1;
    round_start_next = 1'b0;
    press_ign_next   = 1'b0;
    case (state_reg)
      SPIN, STOPPING: begin
        // Only the lowest pressed key is evaluated; any extra keys cost one press_ign.
        if (stop_press != 3'b000) begin
          if (accept) begin
            stop_next[sel] = 1'b1;
            cnt_next       = cnt_reg + 2'd1;
            state_next     = (stop_next == 3'b111) ? DONE : STOPPING;
          end
          press_ign_next = !accept || multi;
        end
      end
      DONE: begin
        if (start_press) begin
          state_next       = SPIN;
          stop_next        = 3'b000;
          cnt_next         = 2'd0;
          timer_next       = '0;
          round_start_next = 1'b1;
        end else if (stop_press != 3'b000) begin
          press_ign_next = 1'b1;
        end
      end
      default: state_next = SPIN;
    endcase
  end

  assign stop        = stop_reg;
  assign stopped_cnt = cnt_reg;
  assign all_stopped = (state_reg == DONE);
  assign round_start = round_start_reg;
  assign press_ign   = press_ign_reg;

endmodule

// File: tb/tb_reel_stop_ctrl.sv
// Directed bench for reel_stop_ctrl with DEB_CYCLES=4, MIN_SPIN_CYCLES=8.
// Covers both builds of ANY_ORDER_EN.
module tb_reel_stop_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] key_n;
  logic       start_n;
  logic [2:0] stop;
  logic [1:0] stopped_cnt;
  logic       all_stopped;
  logic       round_start;
  logic       press_ign;

  int checks;
  int errors;
  int ign_count;
  int rs_count;

  reel_stop_ctrl #(.DEB_CYCLES(4), .MIN_SPIN_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .start_n(start_n),
    .stop(stop),
    .stopped_cnt(stopped_cnt),
    .all_stopped(all_stopped),
    .round_start(round_start),
    .press_ign(press_ign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses last one clock, so sampling on the falling edge counts each exactly once.
  always @(negedge clk) begin
    if (rst) begin
      if (press_ign) ign_count++;
      if (round_start) rs_count++;
    end
  end

  task automatic press_keys(input logic [2:0] mask);
    @(negedge clk);
    key_n = key_n & ~mask;
    repeat (8) @(negedge clk);
    key_n = key_n | mask;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk);
    start_n = 1'b0;
    repeat (8) @(negedge clk);
    start_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_n = 3'b111;
    start_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL reset_stop: got %b expected 000", stop); end
    checks++; if (stopped_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stopped_cnt); end
    checks++; if (all_stopped !== 1'b0) begin errors++; $display("FAIL reset_all_stopped: got %b expected 0", all_stopped); end
    checks++; if ({round_start, press_ign} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {round_start, press_ign}); end
    rst = 1'b1;
    $display("test_reset: stop=%b cnt=%0d", stop, stopped_cnt);
  endtask

  task automatic test_glitch();
    int ign0;
    ign0 = ign_count;
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL glitch_stop: got %b expected 000", stop); end
    checks++; if (ign_count - ign0 !== 0) begin errors++; $display("FAIL glitch_ign: got %0d expected 0", ign_count - ign0); end
    $display("test_glitch: stop=%b", stop);
  endtask

  task automatic test_latency();
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL latency_early: got %b expected 000", stop); end
    @(negedge clk);
    checks++; if (stop !== 3'b001) begin errors++; $display("FAIL latency_stop: got %b expected 001", stop); end
    checks++; if (stopped_cnt !== 2'd1) begin errors++; $display("FAIL latency_cnt: got %0d expected 1", stopped_cnt); end
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    $display("test_latency: stop=%b cnt=%0d", stop, stopped_cnt);
  endtask

  task automatic test_ordered_round();
    int ign0;
    int rs0;
    ign0 = ign_count;
    press_keys(3'b010);
    checks++; if (stop !== 3'b011) begin errors++; $display("FAIL ordered_stop1: got %b expected 011", stop); end
    checks++; if (stopped_cnt !== 2'd2) begin errors++; $display("FAIL ordered_cnt1: got %0d expected 2", stopped_cnt); end
    checks++; if (all_stopped !== 1'b0) begin errors++; $display("FAIL ordered_notdone: got %b expected 0", all_stopped); end
    press_keys(3'b100);
    checks++; if (stop !== 3'b111) begin errors++; $display("FAIL ordered_stop2: got %b expected 111", stop); end
    checks++; if (stopped_cnt !== 2'd3) begin errors++; $display("FAIL ordered_cnt2: got %0d expected 3", stopped_cnt); end
    checks++; if (all_stopped !== 1'b1) begin errors++; $display("FAIL ordered_done: got %b expected 1", all_stopped); end
    checks++; if (ign_count - ign0 !== 0) begin errors++; $display("FAIL ordered_ign: got %0d expected 0", ign_count - ign0); end
    rs0 = rs_count;
    press_start();
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL restart_stop: got %b expected 000", stop); end
    checks++; if (stopped_cnt !== 2'd0) begin errors++; $display("FAIL restart_cnt: got %0d expected 0", stopped_cnt); end
    checks++; if (rs_count - rs0 !== 1) begin errors++; $display("FAIL restart_pulse: got %0d expected 1", rs_count - rs0); end
    checks++; if (all_stopped !== 1'b0) begin errors++; $display("FAIL restart_all_stopped: got %b expected 0", all_stopped); end
    $display("test_ordered_round: stop=%b cnt=%0d", stop, stopped_cnt);
  endtask

`ifdef ANY_ORDER_EN
  task automatic test_any_order();
    press_keys(3'b100);
    checks++; if (stop !== 3'b100) begin errors++; $display("FAIL any_stop1: got %b expected 100", stop); end
    press_keys(3'b001);
    checks++; if (stop !== 3'b101) begin errors++; $display("FAIL any_stop2: got %b expected 101", stop); end
    press_keys(3'b010);
    checks++; if (stop !== 3'b111) begin errors++; $display("FAIL any_stop3: got %b expected 111", stop); end
    checks++; if (all_stopped !== 1'b1) begin errors++; $display("FAIL any_done: got %b expected 1", all_stopped); end
    press_start();
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL any_restart: got %b expected 000", stop); end
    $display("test_any_order: stop=%b", stop);
  endtask
`else
  task automatic test_order_violation();
    int ign0;
    ign0 = ign_count;
    press_keys(3'b100);
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL violation_stop: got %b expected 000", stop); end
    checks++; if (ign_count - ign0 !== 1) begin errors++; $display("FAIL violation_ign: got %0d expected 1", ign_count - ign0); end
    checks++; if (stopped_cnt !== 2'd0) begin errors++; $display("FAIL violation_cnt: got %0d expected 0", stopped_cnt); end
    $display("test_order_violation: stop=%b", stop);
  endtask
`endif

  task automatic test_simultaneous();
    int ign0;
    ign0 = ign_count;
    press_keys(3'b011);
    checks++; if (stop !== 3'b001) begin errors++; $display("FAIL simul_stop: got %b expected 001", stop); end
    checks++; if (ign_count - ign0 !== 1) begin errors++; $display("FAIL simul_ign: got %0d expected 1", ign_count - ign0); end
    $display("test_simultaneous: stop=%b", stop);
  endtask

  task automatic test_start_ignored();
    int ign0;
    int rs0;
    ign0 = ign_count;
    rs0 = rs_count;
    press_start();
    checks++; if (stop !== 3'b001) begin errors++; $display("FAIL startign_stop: got %b expected 001", stop); end
    checks++; if ((ign_count - ign0) + (rs_count - rs0) !== 0) begin errors++; $display("FAIL startign_pulses: got %0d expected 0", (ign_count - ign0) + (rs_count - rs0)); end
    $display("test_start_ignored: stop=%b", stop);
  endtask

  task automatic test_reset_midround();
    press_keys(3'b010);
    checks++; if (stop !== 3'b011) begin errors++; $display("FAIL midrst_pre: got %b expected 011", stop); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL midrst_stop: got %b expected 000", stop); end
    checks++; if (stopped_cnt !== 2'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", stopped_cnt); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    press_keys(3'b001);
    checks++; if (stop !== 3'b001) begin errors++; $display("FAIL midrst_spin: got %b expected 001", stop); end
    $display("test_reset_midround: stop=%b", stop);
  endtask

  task automatic test_min_spin();
    int ign0;
    int rs0;
    press_keys(3'b010);
    press_keys(3'b100);
    checks++; if (all_stopped !== 1'b1) begin errors++; $display("FAIL minspin_done: got %b expected 1", all_stopped); end
    ign0 = ign_count;
    rs0 = rs_count;
    // Key 0 goes low 3 cycles after start, so its press lands ~3 cycles into the new round.
    @(negedge clk);
    start_n = 1'b0;
    repeat (3) @(negedge clk);
    key_n[0] = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (stop !== 3'b000) begin errors++; $display("FAIL minspin_stop: got %b expected 000", stop); end
    checks++; if (rs_count - rs0 !== 1) begin errors++; $display("FAIL minspin_rs: got %0d expected 1", rs_count - rs0); end
    checks++; if (ign_count - ign0 !== 1) begin errors++; $display("FAIL minspin_ign: got %0d expected 1", ign_count - ign0); end
    start_n = 1'b1;
    key_n = 3'b111;
    repeat (12) @(negedge clk);
    press_keys(3'b001);
    checks++; if (stop !== 3'b001) begin errors++; $display("FAIL minspin_after: got %b expected 001", stop); end
    $display("test_min_spin: stop=%b", stop);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ign_count = 0;
    rs_count = 0;
    test_reset();
    test_glitch();
    test_latency();
    test_ordered_round();
`ifdef ANY_ORDER_EN
    test_any_order();
`else
    test_order_violation();
`endif
    test_simultaneous();
    test_start_ignored();
    test_reset_midround();
    test_min_spin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
